// File: rtl/aes_pkg.sv
// Shared AES constants: block/byte widths, InvShiftRows byte map and inverse S-box table.
// Also carries a reference InvShiftRows+InvSubBytes function for checking models.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W   = 128;
    localparam int unsigned AES_BYTE_W    = 8;
    localparam int unsigned AES_NUM_BYTES = AES_BLOCK_W / AES_BYTE_W;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;
    typedef logic [AES_BYTE_W-1:0]  aes_byte_t;

    // Output byte k takes input byte INV_SHIFT_IDX[k]; byte 0 is the MSB byte.
    localparam int unsigned INV_SHIFT_IDX [AES_NUM_BYTES] = '{
        0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3
    };

    localparam aes_byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic aes_block_t inv_shift_sub(input aes_block_t blk);
        aes_block_t r;
        r = '0;
        for (int k = 0; k < AES_NUM_BYTES; k++) begin
            r[AES_BLOCK_W-1-k*AES_BYTE_W -: AES_BYTE_W] =
                INV_SBOX[blk[AES_BLOCK_W-1-INV_SHIFT_IDX[k]*AES_BYTE_W -: AES_BYTE_W]];
        end
        return r;
    endfunction

endpackage

// File: rtl/inv_row_shift_sub_byte_if.sv
// Valid/ready block interface for inv_row_shift_sub_byte.
// iRoundKey exists only when INV_ARK_FUSE_EN is defined.
interface inv_row_shift_sub_byte_if;
    import aes_pkg::*;

    logic       iValid;
    logic       oReady;
    aes_block_t iBlockIn;
    logic       oValid;
    logic       iReady;
    aes_block_t oBlockOut;
`ifdef INV_ARK_FUSE_EN
    aes_block_t iRoundKey;

    modport master (
        output iValid, iBlockIn, iReady, iRoundKey,
        input  oReady, oValid, oBlockOut
    );
    modport slave (
        input  iValid, iBlockIn, iReady, iRoundKey,
        output oReady, oValid, oBlockOut
    );
`else
    modport master (
        output iValid, iBlockIn, iReady,
        input  oReady, oValid, oBlockOut
    );
    modport slave (
        input  iValid, iBlockIn, iReady,
        output oReady, oValid, oBlockOut
    );
`endif

endinterface

// File: rtl/inv_sbox_rom_2p.sv
// Two-read-port inverse S-box ROM with registered outputs and a shared clock enable.
module inv_sbox_rom_2p
    import aes_pkg::*;
(
    input  logic      clk,
    input  logic      clken_i,
    input  aes_byte_t addr_a_i,
    input  aes_byte_t addr_b_i,
    output aes_byte_t data_a_o,
    output aes_byte_t data_b_o
);

    aes_byte_t data_a_q;
    aes_byte_t data_b_q;

    always_ff @(posedge clk) begin
        if (clken_i) begin
            data_a_q <= INV_SBOX[addr_a_i];
            data_b_q <= INV_SBOX[addr_b_i];
        end
    end

    assign data_a_o = data_a_q;
    assign data_b_o = data_b_q;

endmodule

// File: rtl/inv_row_shift_sub_byte.sv
// Two-stage InvShiftRows + InvSubBytes with valid/ready back-pressure, one block per clock.
// Define INV_ARK_FUSE_EN to fold AddRoundKey (iRoundKey) into the output stage.
module inv_row_shift_sub_byte
    import aes_pkg::*;
#(
    parameter int unsigned BLOCK_W = 128,
    parameter int unsigned BYTE_W  = 8
) (
    input logic                     clk,
    input logic                     rst_n,
    inv_row_shift_sub_byte_if.slave bus
);

    if (BLOCK_W != AES_BLOCK_W || BYTE_W != AES_BYTE_W) begin : g_bad_cfg
        $error("inv_row_shift_sub_byte supports only BLOCK_W=128, BYTE_W=8");
    end

    localparam int unsigned NUM_BYTES = BLOCK_W / BYTE_W;

    logic       adv1;
    logic       adv2;
    logic       v1_q, v1_d;
    logic       o_valid_q, o_valid_d;
    aes_block_t o_block_q, o_block_d;
    aes_block_t shifted;
    aes_block_t rom_data;
    aes_block_t stage2_data;

    assign adv2       = !o_valid_q || bus.iReady;
    assign adv1       = !v1_q || adv2;
    assign bus.oReady = adv1;

    for (genvar k = 0; k < NUM_BYTES; k++) begin : g_shift
        assign shifted[BLOCK_W-1-k*BYTE_W -: BYTE_W] =
            bus.iBlockIn[BLOCK_W-1-INV_SHIFT_IDX[k]*BYTE_W -: BYTE_W];
    end

    // ROM output registers are the stage-1 data; clken freezes them during a stall.
    for (genvar j = 0; j < NUM_BYTES / 2; j++) begin : g_rom
        inv_sbox_rom_2p u_rom (
            .clk      (clk),
            .clken_i  (adv1),
            .addr_a_i (shifted[BLOCK_W-1-(2*j)*BYTE_W -: BYTE_W]),
            .addr_b_i (shifted[BLOCK_W-1-(2*j+1)*BYTE_W -: BYTE_W]),
            .data_a_o (rom_data[BLOCK_W-1-(2*j)*BYTE_W -: BYTE_W]),
            .data_b_o (rom_data[BLOCK_W-1-(2*j+1)*BYTE_W -: BYTE_W])
        );
    end

`ifdef INV_ARK_FUSE_EN
    aes_block_t key_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= '0;
        end else if (adv1) begin
            key_q <= bus.iRoundKey;
        end
    end

    assign stage2_data = rom_data ^ key_q;
`else
    assign stage2_data = rom_data;
`endif

    always_comb begin
        v1_d      = v1_q;
        o_valid_d = o_valid_q;
        o_block_d = o_block_q;
        if (adv1) begin
            v1_d = bus.iValid;
        end
        if (adv2) begin
            o_valid_d = v1_q;
            // Bubbles leave the last delivered block on the output.
            if (v1_q) begin
                o_block_d = stage2_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            o_valid_q <= 1'b0;
            o_block_q <= '0;
        end else begin
            v1_q      <= v1_d;
            o_valid_q <= o_valid_d;
            o_block_q <= o_block_d;
        end
    end

    assign bus.oValid    = o_valid_q;
    assign bus.oBlockOut = o_block_q;

endmodule

// File: tb/tb_inv_row_shift_sub_byte.sv
// Directed bench for inv_row_shift_sub_byte: vector table, back-to-back, stall and reset cases.
module tb_inv_row_shift_sub_byte;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    inv_row_shift_sub_byte_if bus ();

    inv_row_shift_sub_byte #(
        .BLOCK_W (128),
        .BYTE_W  (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        aes_block_t din;
        aes_block_t expected;
    } vec_t;

    vec_t       vecs [7];
    aes_block_t sb_q [$];
    aes_block_t sd [3];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_out    = 0;
    int         n0;

    task automatic check(input string name, input aes_block_t act, input aes_block_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Samples the bus mid-cycle; scores deliveries and records accepts.
    task automatic sample();
        @(negedge clk);
        if (rst_n) begin
            if (bus.oValid && bus.iReady) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected_out: got %h, expected no output", bus.oBlockOut);
                end else begin
                    check("sb_order", bus.oBlockOut, sb_q.pop_front());
                end
            end
            if (bus.iValid && bus.oReady) begin
`ifdef INV_ARK_FUSE_EN
                sb_q.push_back(inv_shift_sub(bus.iBlockIn) ^ bus.iRoundKey);
`else
                sb_q.push_back(inv_shift_sub(bus.iBlockIn));
`endif
            end
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.iValid   = 1'b0;
        bus.iReady   = 1'b1;
        bus.iBlockIn = '0;
`ifdef INV_ARK_FUSE_EN
        bus.iRoundKey = '0;
`endif
        vecs[0] = '{din: 128'h63636363_63636363_63636363_63636363,
                    expected: 128'h00000000_00000000_00000000_00000000};
        vecs[1] = '{din: 128'h7ad5fda7_89ef4e27_2bca100b_3d9ff59f,
                    expected: 128'hbd6e7c3d_f2b5779e_0b61216e_8b10b689};
        vecs[2] = '{din: 128'h00000000_00000000_00000000_00000000,
                    expected: 128'h52525252_52525252_52525252_52525252};
        vecs[3] = '{din: 128'hffffffff_ffffffff_ffffffff_ffffffff,
                    expected: 128'h7d7d7d7d_7d7d7d7d_7d7d7d7d_7d7d7d7d};
        vecs[4] = '{din: 128'h63006363_63636363_63636363_63636363,
                    expected: 128'h00000000_00520000_00000000_00000000};
        vecs[5] = '{din: 128'h63636363_63636363_63636363_63006363,
                    expected: 128'h00520000_00000000_00000000_00000000};
        vecs[6] = '{din: 128'h63636300_63636363_63636363_63636363,
                    expected: 128'h00000000_00000000_00000000_00000052};

        repeat (2) @(posedge clk);
        #1;
        check("rst_oValid", bus.oValid, 0);
        check("rst_oBlockOut", bus.oBlockOut, 0);
        check("rst_oReady", bus.oReady, 1);
        rst_n = 1'b1;

        // Single blocks: latency 2, hand-computed results.
        for (int i = 0; i < 7; i++) begin
            next();
            bus.iValid   = 1'b1;
            bus.iBlockIn = vecs[i].din;
            sample();
            next();
            bus.iValid = 1'b0;
            sample();
            check($sformatf("vec%0d_lat1_oValid", i), bus.oValid, 0);
            next();
            sample();
            check($sformatf("vec%0d_oValid", i), bus.oValid, 1);
            check($sformatf("vec%0d_data", i), bus.oBlockOut, vecs[i].expected);
        end
        next();
        sample();
        check("bubble_oValid", bus.oValid, 0);
        check("bubble_hold", bus.oBlockOut, vecs[6].expected);

        // 16 back-to-back random blocks.
        n0 = n_out;
        for (int i = 0; i < 16; i++) begin
            next();
            bus.iValid   = 1'b1;
            bus.iBlockIn = {$urandom(), $urandom(), $urandom(), $urandom()};
            sample();
            check("b2b_oReady", bus.oReady, 1);
            if (i >= 2) check("b2b_oValid", bus.oValid, 1);
        end
        next();
        bus.iValid = 1'b0;
        sample();
        check("b2b_tail1_oValid", bus.oValid, 1);
        next();
        sample();
        check("b2b_tail2_oValid", bus.oValid, 1);
        next();
        sample();
        check("b2b_end_oValid", bus.oValid, 0);
        check("b2b_count", n_out - n0, 16);
        check("b2b_drained", sb_q.size(), 0);

        // Stall: iReady low for 5 cycles while 3 blocks are offered.
        n0 = n_out;
        for (int i = 0; i < 3; i++) sd[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        next();
        bus.iReady   = 1'b0;
        bus.iValid   = 1'b1;
        bus.iBlockIn = sd[0];
        sample();
        check("stall_c0_oReady", bus.oReady, 1);
        next();
        bus.iBlockIn = sd[1];
        sample();
        check("stall_c1_oReady", bus.oReady, 1);
        next();
        bus.iBlockIn = sd[2];
        for (int c = 2; c < 5; c++) begin
            sample();
            check($sformatf("stall_c%0d_oReady", c), bus.oReady, 0);
            check($sformatf("stall_c%0d_oValid", c), bus.oValid, 1);
            check($sformatf("stall_c%0d_hold", c), bus.oBlockOut, inv_shift_sub(sd[0]));
            if (c < 4) next();
        end
        next();
        bus.iReady = 1'b1;
        sample();
        check("stall_release_oReady", bus.oReady, 1);
        check("stall_release_data", bus.oBlockOut, inv_shift_sub(sd[0]));
        next();
        bus.iValid = 1'b0;
        sample();
        check("stall_b_data", bus.oBlockOut, inv_shift_sub(sd[1]));
        next();
        sample();
        check("stall_c_data", bus.oBlockOut, inv_shift_sub(sd[2]));
        next();
        sample();
        check("stall_end_oValid", bus.oValid, 0);
        check("stall_count", n_out - n0, 3);
        check("stall_drained", sb_q.size(), 0);

        // Asynchronous reset with two blocks in flight.
        next();
        bus.iValid   = 1'b1;
        bus.iBlockIn = 128'h01234567_89abcdef_fedcba98_76543210;
        sample();
        next();
        bus.iBlockIn = 128'hdeadbeef_cafef00d_01020304_a5a5a5a5;
        sample();
        next();
        bus.iValid = 1'b0;
        bus.iReady = 1'b0;
        sample();
        check("arst_pre_oValid", bus.oValid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_oValid", bus.oValid, 0);
        check("arst_oBlockOut", bus.oBlockOut, 0);
        check("arst_oReady", bus.oReady, 1);
        sb_q.delete();
        sample();
        next();
        rst_n      = 1'b1;
        bus.iReady = 1'b1;
        n0 = n_out;
        for (int i = 0; i < 5; i++) begin
            sample();
            check("post_rst_oValid", bus.oValid, 0);
            next();
        end
        check("post_rst_count", n_out - n0, 0);

`ifdef INV_ARK_FUSE_EN
        // Fused AddRoundKey with the key changed right after accept.
        bus.iValid    = 1'b1;
        bus.iBlockIn  = 128'h7ad5fda7_89ef4e27_2bca100b_3d9ff59f;
        bus.iRoundKey = 128'h549932d1_f0855768_1093ed9c_be2c974e;
        sample();
        next();
        bus.iValid    = 1'b0;
        bus.iRoundKey = '0;
        sample();
        next();
        sample();
        check("ark_oValid", bus.oValid, 1);
        check("ark_data", bus.oBlockOut, 128'he9f74eec_023020f6_1bf2ccf2_353c21c7);
        next();
`endif

        check("final_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
